score_collector: RTL and testbench
==================================

# score_collector

Collects the ten float32 class scores streamed one per beat from the final dense layer and presents them as a stable parallel array to the downstream argmax stage. It latches the argmax digit once the frame is complete and holds it with a valid/ack handshake for the display/readout logic. The block sits between the output layer and argmax. It owns all sequencing, so argmax stays purely combinational.

## Interface
- N_SCORES, 10, number of class scores per frame (index counter is 4 bits)
- WIDTH, 32, score width (IEEE-754 single, passed through unmodified)

- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- in_data  in  WIDTH  score for current beat, index = beat order 0..9
- in_valid  in  1  upstream beat valid
- in_last  in  1  marks final beat of a frame; must coincide with beat 9
- in_ready  out  1  block can accept a beat
- scores  out  [WIDTH-1:0] [N_SCORES-1:0]  registered score array, wired to argmax inputs
- argmax_number  in  5  digit returned by argmax for the current scores
- result  out  5  latched digit
- result_valid  out  1  result is held and valid
- result_ack  in  1  consumer has taken result
- frame_err  out  1  one-cycle pulse on framing violation

## Operation
- FSM states: FILL, EVAL, HOLD. 4-bit beat counter cnt.
- A beat is accepted when in_valid && in_ready at a rising edge.
- FILL: in_ready=1, result_valid=0.
  - Accepted beat writes scores[cnt] <= in_data.
  - cnt<9 and !in_last: cnt++.
  - cnt<9 and in_last (early last): frame_err pulses, cnt<=0, stay in FILL. The frame is dropped and already-written entries are simply overwritten by the next frame.
  - cnt==9 and in_last: cnt<=0, go to EVAL.
  - cnt==9 and !in_last (missing last): frame_err pulses, cnt<=0, stay in FILL. The frame is dropped.
- EVAL: in_ready=0, scores frozen for argmax to settle. At the next edge: result <= argmax_number, result_valid <= 1, go to HOLD.
- HOLD: in_ready=0, result and scores held. result_ack at an edge: result_valid <= 0, go to FILL.
  - result_ack in FILL or EVAL is ignored.
- scores is written only in FILL and holds its last contents otherwise. argmax output is meaningless during FILL and is sampled only at the end of EVAL.
- Tie-breaking is argmax's rule (lowest index wins). This block does not reinterpret it.
- frame_err is registered and high for exactly one cycle per violation.

## Timing
- Reset values: state=FILL, cnt=0, scores all 0, result=0, result_valid=0, frame_err=0, in_ready=1 once Reset deasserts.
- Reset mid-frame or during HOLD takes effect asynchronously. The partial frame and any pending result are discarded, and the next accepted beat is index 0.
- Latency: last beat accepted at edge k → EVAL during cycle k..k+1 → result_valid high after edge k+1. The digit is captured on the single EVAL cycle.
- Minimum frame period: 10 accept cycles + 1 EVAL + 1 HOLD cycle (ack asserted immediately).
- Bubbles (in_valid low) in FILL simply stall cnt. There is no timeout.
- in_ready depends only on state (registered), with no combinational path from in_valid.
- result_ack and a new in_valid in the same HOLD cycle: ack is taken and the beat is not accepted (in_ready=0). The beat is accepted on the following FILL cycle.

## Test plan
- Nominal frame: 10 beats, all 0x3F800000 (1.0) except beat 7 = 0x40400000 (3.0), in_last on beat 9 → scores[7]=0x40400000, result=7 and result_valid=1 one edge after the last beat, held until result_ack. Then in_ready=1.
- Backpressure: in_valid held high through EVAL/HOLD with data 0xDEADBEEF → in_ready=0 and scores unchanged. After ack, the next frame (beat 2 = 0x40A00000) gives result=2.
- Early last: in_last asserted on beat 4 → frame_err high one cycle, no result_valid. Next clean frame with max at index 0 → result=0.
- Missing last: 10 beats with in_last low → frame_err pulse on beat 9, result_valid stays 0, cnt back to 0.
- Reset after 5 accepted beats, and again during HOLD → outputs immediately at reset values. A following frame with max at index 9 → result=9.
- Bubbly input: in_valid toggled every other cycle with the nominal frame → same result=7. Latency measured from the last accepted beat is unchanged.

Source files
------------

// File: rtl/score_collector.sv
// Collects ten streamed class scores into a parallel array for argmax,
// then latches the argmax digit and holds it under a valid/ack handshake.
module score_collector #(
  parameter int N_SCORES = 10,
  parameter int WIDTH    = 32
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [N_SCORES-1:0][WIDTH-1:0]     scores,
  input  logic [4:0]                         argmax_number,
  output logic [4:0]                         result,
  output logic                               result_valid,
  input  logic                               result_ack,
  output logic                               frame_err
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SCORES - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [N_SCORES-1:0][WIDTH-1:0]  scores_q, scores_d;
  logic [4:0]                      result_q, result_d;
  logic                            rvalid_q, rvalid_d;
  logic                            ferr_q, ferr_d;
  logic                            accept;

  // Ready is a pure function of registered state: no path from in_valid.
  assign in_ready     = (state_q == FILL);
  assign accept       = in_valid && in_ready;
  assign scores       = scores_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;
  assign frame_err    = ferr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scores_d = scores_q;
    result_d = result_q;
    rvalid_d = rvalid_q;
    ferr_d   = 1'b0;
    unique case (state_q)
      FILL: begin
        rvalid_d = 1'b0;
        if (accept) begin
          for (int i = 0; i < N_SCORES; i++) begin
            if (cnt_q == CW'(i)) scores_d[i] = in_data;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (in_last) state_d = EVAL;
            else         ferr_d  = 1'b1;
          end else if (in_last) begin
            cnt_d  = '0;
            ferr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      EVAL: begin
        // Scores have been frozen a full cycle; argmax has settled.
        result_d = argmax_number;
        rvalid_d = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (result_ack) begin
          rvalid_d = 1'b0;
          state_d  = FILL;
        end
      end
      default: begin
        state_d  = FILL;
        cnt_d    = '0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      scores_q <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scores_q <= scores_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      ferr_q   <= ferr_d;
    end
  end

endmodule

// File: tb/tb_score_collector.sv
// Scoreboard bench for score_collector: frames in, expected digits queued,
// popped when result_valid rises.
module tb_score_collector;
  localparam int N = 10;
  localparam int W = 32;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic [W-1:0]         in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic [N-1:0][W-1:0]  scores;
  logic [4:0]           argmax_number;
  logic [4:0]           result;
  logic                 result_valid;
  logic                 result_ack = 1'b0;
  logic                 frame_err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] frame [N];
  logic [4:0]   exp_q [$];

  always #5 Clk = ~Clk;

  score_collector #(.N_SCORES(N), .WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .scores(scores),
    .argmax_number(argmax_number), .result(result),
    .result_valid(result_valid), .result_ack(result_ack),
    .frame_err(frame_err)
  );

  // Downstream argmax stage. Scores used here are all positive floats,
  // so unsigned bit compare orders them correctly; lowest index wins ties.
  always_comb begin
    int b;
    b = 0;
    for (int i = 1; i < N; i++)
      if (scores[i] > scores[b]) b = i;
    argmax_number = 5'(b);
  end

  function automatic logic [4:0] ref_argmax();
    int b;
    b = 0;
    for (int i = 1; i < N; i++)
      if (frame[i] > frame[b]) b = i;
    return 5'(b);
  endfunction

  task automatic fill(input logic [W-1:0] base, input int hi,
                      input logic [W-1:0] hv);
    for (int i = 0; i < N; i++) frame[i] = base;
    frame[hi] = hv;
  endtask

  task automatic send_frame(input int last_at, input bit bubbly,
                            input int nbeats);
    bit lst, err;
    int n;
    for (int i = 0; i < nbeats; i++) begin
      if (last_at >= 0 && i > last_at) break;
      lst = (i == last_at);
      err = (i < 9 && lst) || (i == 9 && !lst);
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = lst;
      n = 0;
      while (!in_ready && n < 40) begin
        @(posedge Clk); #1;
        n++;
      end
      checks++;
      if (n >= 40) begin
        errors++;
        $display("FAIL beat_ready_timeout beat %0d", i);
      end
      @(posedge Clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (frame_err !== err) begin
        errors++;
        $display("FAIL frame_err beat %0d got %b exp %b", i, frame_err, err);
      end
      if (i == 9 && lst) exp_q.push_back(ref_argmax());
      if (bubbly && i < 9 && !lst) begin
        @(posedge Clk); #1;
      end
    end
  endtask

  // Called just after the edge that accepted the last beat (EVAL cycle).
  task automatic check_result(input bit bp, input bit ack_eval,
                              input int hold);
    logic [4:0] e;
    if (bp) begin
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
    end
    checks++;
    if (in_ready !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL eval_state got rdy %b rv %b exp 0 0",
               in_ready, result_valid);
    end
    result_ack = ack_eval;
    @(posedge Clk); #1;
    result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_rv got %b exp 1", result_valid);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries exp 1");
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        errors++;
        $display("FAIL result got %0d exp %0d", result, e);
      end
    end
    for (int c = 0; c < hold; c++) begin
      @(posedge Clk); #1;
      checks++;
      if (result_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d got rv %b rdy %b exp 1 0",
                 c, result_valid, in_ready);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (scores[i] !== frame[i]) begin
        errors++;
        $display("FAIL scores[%0d] got %h exp %h", i, scores[i], frame[i]);
      end
    end
  endtask

  task automatic do_ack(input logic [W-1:0] nextd, input bit with_beat);
    logic [W-1:0] s0;
    s0 = frame[0];
    result_ack = 1'b1;
    in_valid   = with_beat;
    in_data    = nextd;
    @(posedge Clk); #1;
    result_ack = 1'b0;
    in_valid   = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack got rv %b rdy %b exp 0 1", result_valid, in_ready);
    end
    checks++;
    if (scores[0] !== s0) begin
      errors++;
      $display("FAIL ack_no_accept got %h exp %h", scores[0], s0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0 || frame_err !== 1'b0 ||
        result !== 5'd0 || scores !== '0) begin
      errors++;
      $display("FAIL %s got rdy %b rv %b fe %b res %0d exp 1 0 0 0",
               tag, in_ready, result_valid, frame_err, result);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_vals("reset_values");
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_reset_vals("post_reset");
  endtask

  task automatic test_nominal();
    fill(32'h3F800000, 7, 32'h40400000);
    send_frame(9, 1'b0, 10);
    check_result(1'b0, 1'b1, 3);
    do_ack('0, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill(32'h3F800000, 7, 32'h40400000);
    send_frame(9, 1'b0, 10);
    check_result(1'b1, 1'b0, 2);
    do_ack(32'h3F000000, 1'b1);
    fill(32'h3F000000, 2, 32'h40A00000);
    send_frame(9, 1'b0, 10);
    check_result(1'b0, 1'b0, 0);
    do_ack('0, 1'b0);
  endtask

  task automatic test_early_last();
    fill(32'h3F800000, 3, 32'h40000000);
    send_frame(4, 1'b0, 10);
    @(posedge Clk); #1;
    checks++;
    if (frame_err !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_last_after got fe %b rv %b rdy %b exp 0 0 1",
               frame_err, result_valid, in_ready);
    end
    fill(32'h3F800000, 0, 32'h40800000);
    send_frame(9, 1'b0, 10);
    check_result(1'b0, 1'b0, 1);
    do_ack('0, 1'b0);
  endtask

  task automatic test_missing_last();
    fill(32'h3F800000, 4, 32'h40000000);
    send_frame(-1, 1'b0, 10);
    @(posedge Clk); #1;
    checks++;
    if (frame_err !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL missing_last_after got fe %b rv %b rdy %b exp 0 0 1",
               frame_err, result_valid, in_ready);
    end
    fill(32'h3F800000, 6, 32'h40000000);
    send_frame(9, 1'b0, 10);
    check_result(1'b0, 1'b0, 1);
    do_ack('0, 1'b0);
  endtask

  task automatic test_reset_mid();
    fill(32'h3F800000, 9, 32'h40000000);
    send_frame(9, 1'b0, 5);
    #1 Reset = 1'b1;
    #1 check_reset_vals("reset_mid_frame");
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    send_frame(9, 1'b0, 10);
    check_result(1'b0, 1'b0, 1);
    #1 Reset = 1'b1;
    #1 check_reset_vals("reset_in_hold");
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    fill(32'h3F000000, 9, 32'h40400000);
    send_frame(9, 1'b0, 10);
    check_result(1'b0, 1'b0, 1);
    do_ack('0, 1'b0);
  endtask

  task automatic test_bubbly();
    fill(32'h3F800000, 7, 32'h40400000);
    send_frame(9, 1'b1, 10);
    check_result(1'b0, 1'b0, 1);
    do_ack('0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_bubbly();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
